branch_redirect: RTL and testbench

//  EX-stage PC control, directly downstream of the branch comparator: consumes its taken flag

---
 rtl/branch_redirect_if.sv | 26 ++
 rtl/branch_redirect.sv | 106 ++++++++++
 tb/tb_branch_redirect.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/branch_redirect_if.sv
// EX-to-fetch control bundle: branch/jump info in, fetch PC, flushes and trap info out.
interface branch_redirect_if;
  logic        stall;
  logic        ex_valid;
  logic        ex_taken;
  logic        ex_jump;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_exc;
  logic [31:0] exc_pc;
  logic [31:0] taken_count;

  // master: EX/hazard side driving the request; slave: the PC control unit
  modport master (
    output stall, ex_valid, ex_taken, ex_jump, ex_target,
    input  pc, fetch_valid, flush_if_id, flush_id_ex, misalign_exc, exc_pc, taken_count
  );

  modport slave (
    input  stall, ex_valid, ex_taken, ex_jump, ex_target,
    output pc, fetch_valid, flush_if_id, flush_id_ex, misalign_exc, exc_pc, taken_count
  );
endinterface

// File: rtl/branch_redirect.sv
// EX-stage PC control: owns the fetch PC, issues redirects and pipeline flushes,
// squashes fetch for a few cycles after a redirect and traps on misaligned targets.
module branch_redirect #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int unsigned SQUASH_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  branch_redirect_if.slave bus
);

  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    TRAP   = 2'd2
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     exc_pc_q;
  logic [31:0]     taken_count_q;
  logic [CntW-1:0] cnt_q;
  logic            fetch_valid_q;
  logic            misalign_exc_q;

  logic        redirect_c;
  logic [31:0] tgt_c;
  logic        misaligned_c;
  logic        flush_c;

  assign redirect_c   = bus.ex_valid & (bus.ex_taken | bus.ex_jump);
  assign tgt_c        = bus.ex_target & ~32'h0000_0001;
  assign misaligned_c = tgt_c[1];
  // Flushes only make sense while EX can hold a real instruction, i.e. in RUN
  assign flush_c      = (state_q == RUN) & redirect_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_VECTOR;
      exc_pc_q       <= 32'h0;
      taken_count_q  <= 32'h0;
      cnt_q          <= '0;
      fetch_valid_q  <= 1'b1;
      misalign_exc_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // Redirect wins over stall: the instruction in EX is resolving now
          if (redirect_c) begin
            if (misaligned_c) begin
              pc_q           <= TRAP_VECTOR;
              exc_pc_q       <= tgt_c;
              misalign_exc_q <= 1'b1;
              fetch_valid_q  <= 1'b0;
              state_q        <= TRAP;
            end else begin
              pc_q          <= tgt_c;
              taken_count_q <= taken_count_q + 32'd1;
              if (SQUASH_CYCLES > 0) begin
                cnt_q         <= CntW'(SQUASH_CYCLES);
                fetch_valid_q <= 1'b0;
                state_q       <= SQUASH;
              end
            end
          end else if (!bus.stall) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        SQUASH: begin
          if (!bus.stall) begin
            if (cnt_q <= CntW'(1)) begin
              cnt_q         <= '0;
              fetch_valid_q <= 1'b1;
              state_q       <= RUN;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        TRAP: begin
          misalign_exc_q <= 1'b0;
          fetch_valid_q  <= 1'b1;
          state_q        <= RUN;
        end
        default: begin
          misalign_exc_q <= 1'b0;
          fetch_valid_q  <= 1'b1;
          state_q        <= RUN;
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.flush_if_id  = flush_c;
  assign bus.flush_id_ex  = flush_c;
  assign bus.misalign_exc = misalign_exc_q;
  assign bus.exc_pc       = exc_pc_q;
  assign bus.taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: vector table plus hand-written reset-in-squash sequence.
module tb_branch_redirect;

  logic clk;
  logic reset;
  int   nchecks;
  int   nerrors;

  branch_redirect_if bus ();

  branch_redirect #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .SQUASH_CYCLES(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ex_valid;
    logic        ex_taken;
    logic        ex_jump;
    logic [31:0] ex_target;
    logic [31:0] e_pc;
    logic        e_fv;
    logic        e_flush;
    logic        e_mexc;
    logic [31:0] e_exc_pc;
    logic [31:0] e_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic v, input logic tk, input logic jp,
                              input logic [31:0] tgt, input logic [31:0] pc, input logic fv,
                              input logic fl, input logic me, input logic [31:0] epc,
                              input logic [31:0] tc);
    vec_t r;
    r.stall = st; r.ex_valid = v; r.ex_taken = tk; r.ex_jump = jp; r.ex_target = tgt;
    r.e_pc = pc; r.e_fv = fv; r.e_flush = fl; r.e_mexc = me; r.e_exc_pc = epc; r.e_tc = tc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic v, input logic tk, input logic jp,
                       input logic [31:0] tgt);
    bus.stall = st; bus.ex_valid = v; bus.ex_taken = tk; bus.ex_jump = jp; bus.ex_target = tgt;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                           input logic fl, input logic me, input logic [31:0] epc,
                           input logic [31:0] tc);
    check({tag, ".pc"},           bus.pc, pc);
    check({tag, ".fetch_valid"},  32'(bus.fetch_valid), 32'(fv));
    check({tag, ".flush_if_id"},  32'(bus.flush_if_id), 32'(fl));
    check({tag, ".flush_id_ex"},  32'(bus.flush_id_ex), 32'(fl));
    check({tag, ".misalign_exc"}, 32'(bus.misalign_exc), 32'(me));
    check({tag, ".exc_pc"},       bus.exc_pc, epc);
    check({tag, ".taken_count"},  bus.taken_count, tc);
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;

    //          st v  tk jp target        | pc            fv fl me exc_pc        tc
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0, 32'h0,  32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 0, 32'h0,  32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0, 32'h0,  32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_000C, 1, 0, 0, 32'h0,  32'd0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h40,        32'h0000_0010, 1, 1, 0, 32'h0,  32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0040, 0, 0, 0, 32'h0,  32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0040, 1, 0, 0, 32'h0,  32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0044, 1, 0, 0, 32'h0,  32'd1));
    // taken/jump without ex_valid must be ignored
    vecs.push_back(mk(0, 0, 1, 1, 32'h500,       32'h0000_0048, 1, 0, 0, 32'h0,  32'd1));
    vecs.push_back(mk(0, 1, 0, 1, 32'h83,        32'h0000_004C, 1, 1, 0, 32'h0,  32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 0, 1, 32'h82, 32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'h82, 32'd1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 0, 0, 32'h82, 32'd1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 0, 0, 32'h82, 32'd1));
    vecs.push_back(mk(1, 1, 1, 0, 32'h200,       32'h0000_0104, 1, 1, 0, 32'h82, 32'd1));
    // stalled squash holds; redirect during squash is ignored
    vecs.push_back(mk(1, 1, 1, 0, 32'h300,       32'h0000_0200, 0, 0, 0, 32'h82, 32'd2));
    vecs.push_back(mk(0, 1, 0, 1, 32'h300,       32'h0000_0200, 0, 0, 0, 32'h82, 32'd2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0200, 1, 0, 0, 32'h82, 32'd2));
    vecs.push_back(mk(0, 1, 0, 1, 32'h401,       32'h0000_0204, 1, 1, 0, 32'h82, 32'd2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0400, 0, 0, 0, 32'h82, 32'd3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0400, 1, 0, 0, 32'h82, 32'd3));
    vecs.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0000_0404, 1, 1, 0, 32'h82, 32'd3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 0, 32'h82, 32'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 32'h82, 32'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0, 32'h82, 32'd4));
    // misaligned target under stall still traps; count unchanged
    vecs.push_back(mk(1, 1, 1, 0, 32'h0000_0A06, 32'h0000_0004, 1, 1, 0, 32'h82, 32'd4));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 0, 1, 32'hA06, 32'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 1, 0, 0, 32'hA06, 32'd4));

    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].ex_valid, vecs[i].ex_taken, vecs[i].ex_jump, vecs[i].ex_target);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_flush,
                vecs[i].e_mexc, vecs[i].e_exc_pc, vecs[i].e_tc);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-squash returns straight to RUN at the reset vector
    drive(0, 1, 1, 0, 32'h80);
    #1;
    check("rsq.flush", 32'(bus.flush_if_id), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("rsq.pc_tgt", bus.pc, 32'h80);
    check("rsq.fv_squash", 32'(bus.fetch_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_all("rsq.after", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    @(posedge clk); #1;
    check("rsq.pc_inc", bus.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
